// File: rtl/arbitro_pkg.sv
// ----------------------------------------------------------------------------
// arbitro_pkg
// Shared types and default constants for the data-memory arbiter.
//   estado_t : arbiter FSM states (OCIOSO, ACESSO, RESPOSTA)
//   porta_t  : requester identity (CPU, CARGA)
//   *_PADRAO : default values for the memory geometry parameters
// ----------------------------------------------------------------------------
package arbitro_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  typedef enum logic {
    CPU   = 1'b0,
    CARGA = 1'b1
  } porta_t;

  localparam int PALAVRAS_PADRAO = 32;
  localparam int LARGURA_PADRAO  = 32;
  localparam int BITS_END_PADRAO = 5;

endpackage

// File: rtl/arbitro_memoria_dados_if.sv
// ----------------------------------------------------------------------------
// arbitro_memoria_dados_if
// Bus bundle between the two requesters (CPU MEM stage and loader) and the
// data-memory arbiter.
//   cpu_*   : req/escrever/endereco/valor in, ack/saida/stall out
//   carga_* : req/escrever/endereco/valor in, ack/saida out
//   erro    : out-of-range flag, pulses together with the served ack
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface arbitro_memoria_dados_if #(
  parameter int LARGURA = 32
);

  logic               cpu_req;
  logic               cpu_escrever;
  logic [31:0]        cpu_endereco;
  logic [LARGURA-1:0] cpu_valor;
  logic               cpu_ack;
  logic [LARGURA-1:0] cpu_saida;
  logic               cpu_stall;

  logic               carga_req;
  logic               carga_escrever;
  logic [31:0]        carga_endereco;
  logic [LARGURA-1:0] carga_valor;
  logic               carga_ack;
  logic [LARGURA-1:0] carga_saida;

  logic               erro;

  modport master (
    output cpu_req, cpu_escrever, cpu_endereco, cpu_valor,
    input  cpu_ack, cpu_saida, cpu_stall,
    output carga_req, carga_escrever, carga_endereco, carga_valor,
    input  carga_ack, carga_saida,
    input  erro
  );

  modport slave (
    input  cpu_req, cpu_escrever, cpu_endereco, cpu_valor,
    output cpu_ack, cpu_saida, cpu_stall,
    input  carga_req, carga_escrever, carga_endereco, carga_valor,
    output carga_ack, carga_saida,
    output erro
  );

endinterface

// File: rtl/arbitro_memoria_dados_mem.sv
// ----------------------------------------------------------------------------
// memoria_dados_sinc
// PALAVRAS x LARGURA synchronous RAM: write on the rising edge when we_i is
// high, read data registered on the rising edge when re_i is high.
//   clock            : rising-edge clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i/rdata_o : registered read port
// The caller guarantees addresses are in range when we_i is asserted.
// ----------------------------------------------------------------------------
module memoria_dados_sinc #(
  parameter int PALAVRAS = 32,
  parameter int LARGURA  = 32,
  parameter int BITS_END = 5
) (
  input  logic                clock,
  input  logic                we_i,
  input  logic [BITS_END-1:0] waddr_i,
  input  logic [LARGURA-1:0]  wdata_i,
  input  logic                re_i,
  input  logic [BITS_END-1:0] raddr_i,
  output logic [LARGURA-1:0]  rdata_o
);

  logic [LARGURA-1:0] mem_q [PALAVRAS];
  logic [LARGURA-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/arbitro_memoria_dados.sv
// ----------------------------------------------------------------------------
// arbitro_memoria_dados
// Round-robin arbiter and controller for the MEM-stage data memory shared by
// the CPU and the loader. Each access takes OCIOSO -> ACESSO -> RESPOSTA:
// ack arrives two cycles after req is first sampled, one access per 3 cycles.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : arbitro_memoria_dados_if.slave (both requester ports + erro)
// ----------------------------------------------------------------------------
module arbitro_memoria_dados
  import arbitro_pkg::*;
#(
  parameter int PALAVRAS = PALAVRAS_PADRAO,
  parameter int LARGURA  = LARGURA_PADRAO,
  parameter int BITS_END = BITS_END_PADRAO
) (
  input  logic                    clock,
  input  logic                    reset,
  arbitro_memoria_dados_if.slave  bus
);

  estado_t            estado_q, estado_d;
  porta_t             ultimo_q, ultimo_d;
  porta_t             porta_q, porta_d;
  logic               escrever_q, escrever_d;
  logic [31:0]        endereco_q, endereco_d;
  logic [LARGURA-1:0] valor_q, valor_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic               carga_ack_q, carga_ack_d;
  logic               erro_q, erro_d;
  logic [LARGURA-1:0] cpu_saida_q, cpu_saida_d;
  logic [LARGURA-1:0] carga_saida_q, carga_saida_d;

  porta_t             porta_sel;
  logic               sel_escrever;
  logic [31:0]        sel_endereco;
  logic [LARGURA-1:0] sel_valor;
  logic               algum_req;
  logic               fora;
  logic               mem_we;
  logic               mem_re;
  logic [LARGURA-1:0] mem_rdata;

  assign algum_req = bus.cpu_req || bus.carga_req;

  // Arbitration: on a tie the port that was not served by the last tie wins.
  // ultimo only moves on ties, so a lone requester does not steal priority.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    porta_sel = CPU;
    if (bus.cpu_req && bus.carga_req) begin
      porta_sel = (ultimo_q == CARGA) ? CPU : CARGA;
    end else if (bus.carga_req) begin
      porta_sel = CARGA;
    end
    sel_escrever = (porta_sel == CARGA) ? bus.carga_escrever : bus.cpu_escrever;
    sel_endereco = (porta_sel == CARGA) ? bus.carga_endereco : bus.cpu_endereco;
    sel_valor    = (porta_sel == CARGA) ? bus.carga_valor    : bus.cpu_valor;
  end

  // Upper address bits set, or an index past the last word, is out of range.
  assign fora = ((endereco_q >> BITS_END) != 32'd0) ||
                (32'(endereco_q[BITS_END-1:0]) >= 32'(PALAVRAS));

  // Write at the edge closing ACESSO; reset on that edge suppresses it.
  assign mem_we = (estado_q == ACESSO) && escrever_q && !fora && !reset;

  // The read is launched while granting, so the RAM output is ready during
  // ACESSO and can be registered into saida at the edge closing ACESSO.
  assign mem_re = (estado_q == OCIOSO) && algum_req && !sel_escrever;

  memoria_dados_sinc #(
    .PALAVRAS (PALAVRAS),
    .LARGURA  (LARGURA),
    .BITS_END (BITS_END)
  ) u_mem (
    .clock   (clock),
    .we_i    (mem_we),
    .waddr_i (endereco_q[BITS_END-1:0]),
    .wdata_i (valor_q),
    .re_i    (mem_re),
    .raddr_i (sel_endereco[BITS_END-1:0]),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    estado_d      = estado_q;
    ultimo_d      = ultimo_q;
    porta_d       = porta_q;
    escrever_d    = escrever_q;
    endereco_d    = endereco_q;
    valor_d       = valor_q;
    cpu_ack_d     = 1'b0;
    carga_ack_d   = 1'b0;
    erro_d        = 1'b0;
    cpu_saida_d   = cpu_saida_q;
    carga_saida_d = carga_saida_q;

    case (estado_q)
      OCIOSO: begin
        if (algum_req) begin
          if (bus.cpu_req && bus.carga_req) ultimo_d = porta_sel;
          porta_d    = porta_sel;
          escrever_d = sel_escrever;
          endereco_d = sel_endereco;
          valor_d    = sel_valor;
          estado_d   = ACESSO;
        end
      end

      ACESSO: begin
        if (!escrever_q) begin
          if (porta_q == CPU) cpu_saida_d   = fora ? '0 : mem_rdata;
          else                carga_saida_d = fora ? '0 : mem_rdata;
        end
        cpu_ack_d   = (porta_q == CPU);
        carga_ack_d = (porta_q == CARGA);
        erro_d      = fora;
        estado_d    = RESPOSTA;
      end

      RESPOSTA: estado_d = OCIOSO;

      default: estado_d = OCIOSO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q      <= OCIOSO;
      ultimo_q      <= CARGA;
      porta_q       <= CPU;
      escrever_q    <= 1'b0;
      endereco_q    <= '0;
      valor_q       <= '0;
      cpu_ack_q     <= 1'b0;
      carga_ack_q   <= 1'b0;
      erro_q        <= 1'b0;
      cpu_saida_q   <= '0;
      carga_saida_q <= '0;
    end else begin
      estado_q      <= estado_d;
      ultimo_q      <= ultimo_d;
      porta_q       <= porta_d;
      escrever_q    <= escrever_d;
      endereco_q    <= endereco_d;
      valor_q       <= valor_d;
      cpu_ack_q     <= cpu_ack_d;
      carga_ack_q   <= carga_ack_d;
      erro_q        <= erro_d;
      cpu_saida_q   <= cpu_saida_d;
      carga_saida_q <= carga_saida_d;
    end
  end

  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.carga_ack   = carga_ack_q;
  assign bus.erro        = erro_q;
  assign bus.cpu_saida   = cpu_saida_q;
  assign bus.carga_saida = carga_saida_q;
  assign bus.cpu_stall   = bus.cpu_req && !cpu_ack_q;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// ----------------------------------------------------------------------------
// tb_arbitro_memoria_dados
// Directed and randomized bench for arbitro_memoria_dados. A reference model
// (word array, tie-winner bit, last read value per port) predicts every
// response. Inputs change on the falling edge, outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_arbitro_memoria_dados;

  localparam int PALAVRAS = 32;
  localparam int LARGURA  = 32;
  localparam int BITS_END = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  arbitro_memoria_dados_if #(.LARGURA(LARGURA)) bus ();

  arbitro_memoria_dados #(
    .PALAVRAS (PALAVRAS),
    .LARGURA  (LARGURA),
    .BITS_END (BITS_END)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: port 0 = cpu, port 1 = carga.
  logic [31:0] mem_ref [PALAVRAS];
  bit          ultimo_ref;           // 1 = carga won the last tie
  logic [31:0] saida_ref [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input bit p, input bit req, input bit wr,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 1'b0) begin
      bus.cpu_req = req; bus.cpu_escrever = wr; bus.cpu_endereco = a; bus.cpu_valor = d;
    end else begin
      bus.carga_req = req; bus.carga_escrever = wr; bus.carga_endereco = a; bus.carga_valor = d;
    end
  endtask

  function automatic logic get_ack(input bit p);
    return (p == 1'b0) ? bus.cpu_ack : bus.carga_ack;
  endfunction

  // Apply one served access to the model and compare all response outputs.
  task automatic served(input bit p, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    bit out_of_range;
    out_of_range = (a >= 32'(PALAVRAS));
    if (wr) begin
      if (!out_of_range) mem_ref[a] = d;
    end else begin
      saida_ref[p] = out_of_range ? 32'd0 : mem_ref[a];
    end
    check({tag, "_erro"}, 32'(bus.erro), 32'(out_of_range));
    check({tag, "_saida_cpu"}, bus.cpu_saida, saida_ref[0]);
    check({tag, "_saida_carga"}, bus.carga_saida, saida_ref[1]);
    check({tag, "_outro_ack"}, 32'(get_ack(!p)), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    ultimo_ref   = 1'b1;
    saida_ref[0] = 32'd0;
    saida_ref[1] = 32'd0;
  endtask

  // One access on one port; ack expected two cycles after the request cycle.
  task automatic run_single(input bit p, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input string tag);
    int n_ack;
    int stall_n;
    n_ack   = 0;
    stall_n = 0;
    @(negedge clock);
    set_port(p, 1'b1, wr, a, d);
    #1;
    stall_n += int'(bus.cpu_stall);
    for (int n = 1; n <= 6 && n_ack == 0; n++) begin
      @(negedge clock);
      if (get_ack(p)) begin
        n_ack = n;
        if (p == 1'b0) check({tag, "_stall_no_ack"}, 32'(bus.cpu_stall), 32'd0);
        served(p, wr, a, d, tag);
        set_port(p, 1'b0, wr, a, d);
      end else begin
        stall_n += int'(bus.cpu_stall);
      end
    end
    check({tag, "_latencia"}, 32'(n_ack), 32'd2);
    if (p == 1'b0) check({tag, "_stall_ciclos"}, 32'(stall_n), 32'd2);
    set_port(p, 1'b0, wr, a, d);
  endtask

  // Both ports request in the same cycle; the tie winner is served first.
  task automatic run_pair(input bit cwr, input logic [31:0] ca, input logic [31:0] cd,
                          input bit gwr, input logic [31:0] ga, input logic [31:0] gd,
                          input string tag);
    bit first;
    int n_c;
    int n_g;
    first      = (ultimo_ref == 1'b1) ? 1'b0 : 1'b1;
    ultimo_ref = first;
    n_c = 0;
    n_g = 0;
    @(negedge clock);
    set_port(1'b0, 1'b1, cwr, ca, cd);
    set_port(1'b1, 1'b1, gwr, ga, gd);
    for (int n = 1; n <= 8 && (n_c == 0 || n_g == 0); n++) begin
      @(negedge clock);
      if (bus.cpu_ack && n_c == 0) begin
        n_c = n;
        served(1'b0, cwr, ca, cd, {tag, "_cpu"});
        set_port(1'b0, 1'b0, cwr, ca, cd);
      end
      if (bus.carga_ack && n_g == 0) begin
        n_g = n;
        served(1'b1, gwr, ga, gd, {tag, "_carga"});
        set_port(1'b1, 1'b0, gwr, ga, gd);
      end
    end
    check({tag, "_lat_cpu"},   32'(n_c), (first == 1'b0) ? 32'd2 : 32'd5);
    check({tag, "_lat_carga"}, 32'(n_g), (first == 1'b1) ? 32'd2 : 32'd5);
    set_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_0020;
    else                           a = 32'($urandom_range(0, PALAVRAS - 1));
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          mask;
    int          cpu_acks;
    logic [31:0] addr5;
    set_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Reset state.
    check("rst_cpu_ack",     32'(bus.cpu_ack),   32'd0);
    check("rst_carga_ack",   32'(bus.carga_ack), 32'd0);
    check("rst_erro",        32'(bus.erro),      32'd0);
    check("rst_cpu_saida",   bus.cpu_saida,      32'd0);
    check("rst_carga_saida", bus.carga_saida,    32'd0);
    check("rst_cpu_stall",   32'(bus.cpu_stall), 32'd0);
    reset        = 1'b0;
    ultimo_ref   = 1'b1;
    saida_ref[0] = 32'd0;
    saida_ref[1] = 32'd0;

    // Give every word a known value through the loader.
    for (int i = 0; i < PALAVRAS; i++) begin
      run_single(1'b1, 1'b1, 32'(i), 32'hC0DE_0000 | 32'(i), $sformatf("init%0d", i));
    end

    // 1: cpu write then read of address 5.
    run_single(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, "t1_wr");
    run_single(1'b0, 1'b0, 32'd5, 32'd0,         "t1_rd");
    addr5 = 32'hDEAD_BEEF;
    check("t1_valor", bus.cpu_saida, addr5);

    // 2: simultaneous reads after reset; cpu wins first, carga the next tie.
    do_reset();
    run_pair(1'b0, 32'd10, 32'd0, 1'b0, 32'd11, 32'd0, "t2a");
    run_pair(1'b0, 32'd12, 32'd0, 1'b0, 32'd13, 32'd0, "t2b");

    // 3: out-of-range write is dropped and flagged; aliased word untouched.
    run_single(1'b1, 1'b1, 32'd40, 32'h1234_5678, "t3_wr40");
    run_single(1'b1, 1'b0, 32'd8,  32'd0,         "t3_rd8");
    run_single(1'b1, 1'b0, 32'd40, 32'd0,         "t3_rd40");

    // 4: reset during ACESSO aborts a cpu write to address 3.
    @(negedge clock);
    set_port(1'b0, 1'b1, 1'b1, 32'd3, 32'hAAAA_5555);
    @(negedge clock);
    reset = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check("t4_ack_abortado", 32'(bus.cpu_ack), 32'd0);
    check("t4_erro",         32'(bus.erro),    32'd0);
    reset        = 1'b0;
    ultimo_ref   = 1'b1;
    saida_ref[0] = 32'd0;
    saida_ref[1] = 32'd0;
    run_single(1'b0, 1'b0, 32'd3, 32'd0, "t4_rd3");

    // 5: carga holds req for 9 cycles, reading a new address after each ack.
    mask     = 0;
    cpu_acks = 0;
    @(negedge clock);
    set_port(1'b1, 1'b1, 1'b0, 32'd20, 32'd0);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (bus.cpu_ack) cpu_acks++;
      if (bus.carga_ack) begin
        mask |= (1 << n);
        served(1'b1, 1'b0, bus.carga_endereco, 32'd0, $sformatf("t5_ack%0d", n));
        set_port(1'b1, 1'b1, 1'b0, bus.carga_endereco + 32'd1, 32'd0);
      end
      if (n == 8) set_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    check("t5_padrao_ack", 32'(mask), 32'((1 << 2) | (1 << 5) | (1 << 8)));
    check("t5_cpu_ack",    32'(cpu_acks), 32'd0);

    // 6: cpu drops req during ACESSO; the write still completes with an ack.
    @(negedge clock);
    set_port(1'b0, 1'b1, 1'b1, 32'd7, 32'h7777_0007);
    @(negedge clock);
    set_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check("t6_ack", 32'(bus.cpu_ack), 32'd1);
    served(1'b0, 1'b1, 32'd7, 32'h7777_0007, "t6_wr7");
    run_single(1'b0, 1'b0, 32'd7, 32'd0, "t6_rd7");

    // Randomized mix of single and simultaneous accesses.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 2))
        0: run_single(1'b0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, $sformatf("rnd%0d_cpu", k));
        1: run_single(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, $sformatf("rnd%0d_carga", k));
        default: run_pair(1'($urandom_range(0, 1)), rand_addr(), $urandom,
                          1'($urandom_range(0, 1)), rand_addr(), $urandom,
                          $sformatf("rnd%0d_par", k));
      endcase
    end

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria_dados.md
Name: arbitro_memoria_dados

Overview:
Controller and arbiter for the 32-word data memory used by the pipeline's fifth (MEM) stage. It shares the memory between two requesters: the CPU MEM stage (port cpu) and the program/data loader (port carga). The memory array is owned by this block as a synchronous RAM. Each requester gets a req/ack handshake, and the CPU gets a stall signal that holds the pipeline while its access is pending.

Parameters:
PALAVRAS, 32, number of memory words; addresses >= PALAVRAS are out of range.
LARGURA, 32, data width in bits.
BITS_END, 5, index width (clog2 of PALAVRAS); only addr[BITS_END-1:0] indexes the array.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  synchronous, active-high.
cpu_req  input  1  CPU requests an access; held until cpu_ack.
cpu_escrever  input  1  1 = write, 0 = read; stable while cpu_req is high.
cpu_endereco  input  32  word address.
cpu_valor  input  LARGURA  write data.
cpu_ack  output  1  one-cycle completion pulse.
cpu_saida  output  LARGURA  read data, valid in the cpu_ack cycle.
cpu_stall  output  1  cpu_req && !cpu_ack (combinational); freezes the pipeline.
carga_req, carga_escrever, carga_endereco, carga_valor  input  1/1/32/LARGURA  same rules as the cpu_* inputs.
carga_ack  output  1  completion pulse for carga.
carga_saida  output  LARGURA  read data, valid in the carga_ack cycle.
erro  output  1  pulses with ack when the served address was out of range.

Behaviour:
- Reset values: state OCIOSO; all ack outputs 0; cpu_saida 0; carga_saida 0; erro 0; ultimo = CARGA, so the CPU wins the first tie. Memory contents are not cleared.
- FSM states: OCIOSO, ACESSO, RESPOSTA.
- OCIOSO:
  - Only one req high: latch that port id, its write flag, its address and its data. Go to ACESSO.
  - Both req high: grant the port that is not ultimo, then update ultimo (round-robin).
  - No req: stay in OCIOSO.
- ACESSO (exactly one cycle):
  - Write: the array is written at the closing edge, only if the address is in range.
  - Read: the array output is registered into the granted port's saida. An out-of-range read registers 0.
  - Go to RESPOSTA.
- RESPOSTA: ack high for the granted port only; erro high if the address was out of range. Then go to OCIOSO.
- Latency: req first sampled high in cycle N, ack in cycle N+2, earliest next grant in cycle N+3. Throughput is one access per 3 cycles.
- The saida outputs hold their value until the next read on that same port. The ungranted port's saida is unchanged.
- Inputs are sampled only in OCIOSO. Changing inputs during ACESSO or RESPOSTA has no effect on the transaction in flight.
- If req drops before ack, the latched transaction still completes and ack still pulses. The requester ignores that pulse.
- A requester still asserting req after its ack is treated as a new request and arbitrated again in the next OCIOSO.
- Reset mid-operation: reset wins at any edge. A write whose ACESSO edge coincides with reset is suppressed. FSM returns to OCIOSO with no ack.
- Address width rule: addr[31:BITS_END] != 0, or index >= PALAVRAS, means out of range. Write is ignored, read returns 0, erro pulses.

Decomposition:
- Package arbitro_pkg holds:
  - state enum (OCIOSO=2'd0, ACESSO=2'd1, RESPOSTA=2'd2);
  - port ids (CPU=1'b0, CARGA=1'b1);
  - default parameter constants.
- One sub-module: memoria_dados_sinc, the PALAVRAS x LARGURA array with synchronous write enable and registered read. Instantiated once.
- Arbitration, FSM and output registers stay in the top module.

Test Plan:
1. Reset, then cpu write 0xDEADBEEF to addr 5, then cpu read addr 5 -> each cpu_ack arrives 2 cycles after req; cpu_saida = 0xDEADBEEF; cpu_stall high for exactly 2 cycles per access.
2. cpu_req and carga_req raised in the same cycle after reset, both reads -> cpu served first (ack at N+2), carga ack at N+5. On a second simultaneous pair, carga wins first.
3. carga write 0x12345678 to addr 40 -> carga_ack with erro=1; a later read of addr 8 (40 & 31) does not return 0x12345678; a read of addr 40 returns 0 with erro=1.
4. cpu write 0xAAAA5555 to addr 3, with reset asserted in the ACESSO cycle, then read addr 3 -> no ack for the aborted write; old value returned.
5. carga holds req high for 9 cycles while cpu is idle -> three carga_ack pulses at cycles 2, 5 and 8; cpu_ack stays 0; carga_saida updates on each read.
6. cpu_req dropped during ACESSO on a write to addr 7 -> cpu_ack still pulses; addr 7 contains the written value.
